// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment receive path: blank pattern, hex code table, FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {a,b,c,d,e,f,g} patterns for hex digits 0..F
  localparam logic [6:0] SEG_CODES [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Combinational reverse lookup of an active-low segment pattern into a hex value.
// legal flags a hex code only; the all-off pattern is reported separately via is_blank.
module seg7_pattern_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic       legal,
  output logic       is_blank,
  output logic [3:0] value
);

  always_comb begin
    legal    = 1'b0;
    value    = 4'd0;
    is_blank = (seg_n == SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (seg_n == SEG_CODES[i]) begin
        legal = 1'b1;
        value = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a scanned active-low 7-segment/anode bus and rebuilds per-digit hex, dp and blank state.
// state | meaning: IDLE no anode low | SETTLE tuple changed, counting | HOLD tuple processed.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_DIGITS-1:0]   an_n,
  input  logic [6:0]            seg_n,
  input  logic                  p,
  output logic [4*N_DIGITS-1:0] hex_out,
  output logic [N_DIGITS-1:0]   dp_out,
  output logic [N_DIGITS-1:0]   blank,
  output logic [N_DIGITS-1:0]   digit_valid,
  output logic                  upd,
  output logic [2:0]            upd_idx,
  output logic                  pat_err,
  output logic                  an_err,
  output logic                  frame_done
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  scan_state_t state_q, state_d;
  logic [N_DIGITS-1:0]   s_an_q, s_an_d;
  logic [6:0]            s_seg_q, s_seg_d;
  logic                  s_p_q, s_p_d;
  logic                  chg_q, chg_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4*N_DIGITS-1:0] hex_q, hex_d;
  logic [N_DIGITS-1:0]   dp_q, dp_d, blank_q, blank_d, valid_q, valid_d, seen_q, seen_d;
  logic                  upd_q, upd_d, pat_err_q, pat_err_d, an_err_q, an_err_d, fd_q, fd_d;
  logic [2:0]            upd_idx_q, upd_idx_d;
  logic [TW-1:0]         tcnt_q [N_DIGITS];
  logic [TW-1:0]         tcnt_d [N_DIGITS];

  logic [N_DIGITS-1:0] an_low, cap_oh, seen_nxt;
  logic                lk_legal, lk_blank;
  logic [3:0]          lk_value;

  seg7_pattern_lookup u_lookup (
    .seg_n    (s_seg_q),
    .legal    (lk_legal),
    .is_blank (lk_blank),
    .value    (lk_value)
  );

  always_comb begin
    s_an_d    = an_n;
    s_seg_d   = seg_n;
    s_p_d     = p;
    chg_d     = ({an_n, seg_n, p} != {s_an_q, s_seg_q, s_p_q});
    state_d   = state_q;
    cnt_d     = cnt_q;
    hex_d     = hex_q;
    dp_d      = dp_q;
    blank_d   = blank_q;
    valid_d   = valid_q;
    seen_d    = seen_q;
    upd_d     = 1'b0;
    upd_idx_d = upd_idx_q;
    pat_err_d = 1'b0;
    an_err_d  = 1'b0;
    fd_d      = 1'b0;
    tcnt_d    = tcnt_q;
    an_low    = ~s_an_q;
    cap_oh    = '0;
    seen_nxt  = seen_q;

    if (chg_q) begin
      cnt_d   = CW'(1);
      state_d = (|an_low) ? ST_SETTLE : ST_IDLE;
    end else if (state_q == ST_SETTLE) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_d == CW'(STABLE_CYCLES)) begin
        state_d = ST_HOLD;
        if ((an_low & (an_low - N_DIGITS'(1))) != '0) an_err_d = 1'b1;
        else if (lk_legal || lk_blank)                 cap_oh   = an_low;
        else                                           pat_err_d = 1'b1;
      end
    end

    for (int i = 0; i < N_DIGITS; i++) begin
      if (cap_oh[i]) begin
        if (!lk_blank) hex_d[4*i +: 4] = lk_value;
        blank_d[i]  = lk_blank;
        dp_d[i]     = s_p_q;
        valid_d[i]  = 1'b1;
        tcnt_d[i]   = '0;
        upd_d       = 1'b1;
        upd_idx_d   = 3'(i);
      end else if (tcnt_q[i] < TW'(TIMEOUT)) begin
        tcnt_d[i] = tcnt_q[i] + TW'(1);
        if (tcnt_d[i] == TW'(TIMEOUT)) valid_d[i] = 1'b0;
      end
    end

    // The capture that completes the frame is not carried into the next one
    if (upd_d) begin
      seen_nxt = seen_q | cap_oh;
      if (&seen_nxt) begin
        fd_d   = 1'b1;
        seen_d = '0;
      end else begin
        seen_d = seen_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      s_an_q    <= '1;
      s_seg_q   <= SEG_BLANK;
      s_p_q     <= 1'b0;
      chg_q     <= 1'b0;
      cnt_q     <= '0;
      hex_q     <= '0;
      dp_q      <= '0;
      blank_q   <= '0;
      valid_q   <= '0;
      seen_q    <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= '0;
      pat_err_q <= 1'b0;
      an_err_q  <= 1'b0;
      fd_q      <= 1'b0;
      tcnt_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      s_an_q    <= s_an_d;
      s_seg_q   <= s_seg_d;
      s_p_q     <= s_p_d;
      chg_q     <= chg_d;
      cnt_q     <= cnt_d;
      hex_q     <= hex_d;
      dp_q      <= dp_d;
      blank_q   <= blank_d;
      valid_q   <= valid_d;
      seen_q    <= seen_d;
      upd_q     <= upd_d;
      upd_idx_q <= upd_idx_d;
      pat_err_q <= pat_err_d;
      an_err_q  <= an_err_d;
      fd_q      <= fd_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign hex_out     = hex_q;
  assign dp_out      = dp_q;
  assign blank       = blank_q;
  assign digit_valid = valid_q;
  assign upd         = upd_q;
  assign upd_idx     = upd_idx_q;
  assign pat_err     = pat_err_q;
  assign an_err      = an_err_q;
  assign frame_done  = fd_q;

endmodule
